// File: rtl/stopwatch_sequencer.sv
// Control FSM for the stopwatch: turns button pulses and the 10 Hz tick into
// registered run/clear/snapshot strobes, display-source select and HEX4 mode code.
module stopwatch_sequencer #(
  parameter int HOLD_TICKS  = 50,
  parameter int BLINK_TICKS = 5,
  parameter int MODE_TOTAL  = 5,
  parameter int MODE_LAP    = 10,
  parameter int MODE_BLINK  = 11
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       tick,
  input  logic       start_stop,
  input  logic       lap_clear,
  input  logic       mode_sel,
  output logic       run_total,
  output logic       run_lap,
  output logic       clr_total,
  output logic       clr_lap,
  output logic       snap_load,
  output logic [1:0] disp_src,
  output logic [3:0] mode_code,
  output logic       hold_active,
  output logic [1:0] state_dbg
);

  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_TICKS - 1);
  localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_TICKS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2, PAUSE = 2'd3} state_t;

  state_t          state_q, state_d;
  logic            mode_q, mode_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            blink_q, blink_d;
  logic            run_q, run_d;
  logic            clr_total_q, clr_total_d;
  logic            clr_lap_q, clr_lap_d;
  logic            snap_load_q, snap_load_d;
  logic [1:0]      disp_src_q, disp_src_d;
  logic [3:0]      mode_code_q, mode_code_d;
  logic            hold_active_q, hold_active_d;

  logic ss_ev, lc_ev, ms_ev;
  logic lap_act, clr_all;

  // Priority start_stop > lap_clear > mode_sel; lower ones in the same cycle are dropped.
  assign ss_ev = start_stop;
  assign lc_ev = lap_clear & ~start_stop;
  assign ms_ev = mode_sel & ~start_stop & ~lap_clear;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q       <= IDLE;
      mode_q        <= 1'b0;
      hold_cnt_q    <= '0;
      blink_cnt_q   <= '0;
      blink_q       <= 1'b0;
      run_q         <= 1'b0;
      clr_total_q   <= 1'b1;
      clr_lap_q     <= 1'b1;
      snap_load_q   <= 1'b0;
      disp_src_q    <= 2'd0;
      mode_code_q   <= 4'(MODE_TOTAL);
      hold_active_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      hold_cnt_q    <= hold_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_q       <= blink_d;
      run_q         <= run_d;
      clr_total_q   <= clr_total_d;
      clr_lap_q     <= clr_lap_d;
      snap_load_q   <= snap_load_d;
      disp_src_q    <= disp_src_d;
      mode_code_q   <= mode_code_d;
      hold_active_q <= hold_active_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q ^ ms_ev;
    hold_cnt_d  = hold_cnt_q;
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    lap_act     = 1'b0;
    clr_all     = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_ev)      state_d = RUN;
        else if (lc_ev) clr_all = 1'b1;
      end
      RUN: begin
        if (ss_ev)      state_d = PAUSE;
        else if (lc_ev) lap_act = 1'b1;
      end
      HOLD: begin
        if (ss_ev) begin
          state_d = PAUSE;
        end else if (lc_ev) begin
          lap_act = 1'b1;
        end else if (tick) begin
          if (hold_cnt_q == '0) state_d = RUN;
          else                  hold_cnt_d = hold_cnt_q - 1'b1;
          if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
          end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
          end
        end
      end
      PAUSE: begin
        if (ss_ev) begin
          state_d = RUN;
        end else if (lc_ev) begin
          clr_all = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (lap_act) begin
      state_d     = HOLD;
      hold_cnt_d  = HOLD_RELOAD;
      blink_cnt_d = '0;
      blink_d     = 1'b1;
    end
    // Hold bookkeeping only lives inside HOLD; leaving it discards it.
    if (state_d != HOLD) begin
      hold_cnt_d  = '0;
      blink_cnt_d = '0;
      blink_d     = 1'b0;
    end
  end

  always_comb begin
    hold_active_d = (state_d == HOLD);
    run_d         = (state_d == RUN) || (state_d == HOLD);
    clr_total_d   = clr_all;
    clr_lap_d     = clr_all | lap_act;
    snap_load_d   = lap_act;
    disp_src_d    = hold_active_d ? 2'd2 : {1'b0, mode_d};
    if (hold_active_d && blink_d) mode_code_d = 4'(MODE_BLINK);
    else if (mode_d)              mode_code_d = 4'(MODE_LAP);
    else                          mode_code_d = 4'(MODE_TOTAL);
  end

  assign run_total   = run_q;
  assign run_lap     = run_q;
  assign clr_total   = clr_total_q;
  assign clr_lap     = clr_lap_q;
  assign snap_load   = snap_load_q;
  assign disp_src    = disp_src_q;
  assign mode_code   = mode_code_q;
  assign hold_active = hold_active_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_stopwatch_sequencer.sv
// Directed bench for stopwatch_sequencer: a vector table for single-cycle behaviour
// plus hand-written HOLD timing, retrigger and reset-mid-HOLD sequences.
module tb_stopwatch_sequencer;

  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_HOLD = 2'd2, S_PAUSE = 2'd3;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0, start_stop = 1'b0, lap_clear = 1'b0, mode_sel = 1'b0;
  logic       run_total, run_lap, clr_total, clr_lap, snap_load, hold_active;
  logic [1:0] disp_src, state_dbg;
  logic [3:0] mode_code;
  logic [13:0] obs;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        ss, lc, ms, tk;
    logic [13:0] exp;
    string       name;
  } vec_t;
  vec_t vecs[$];

  stopwatch_sequencer dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .tick(tick), .start_stop(start_stop),
    .lap_clear(lap_clear), .mode_sel(mode_sel), .run_total(run_total), .run_lap(run_lap),
    .clr_total(clr_total), .clr_lap(clr_lap), .snap_load(snap_load), .disp_src(disp_src),
    .mode_code(mode_code), .hold_active(hold_active), .state_dbg(state_dbg)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  assign obs = {run_total, run_lap, clr_total, clr_lap, snap_load, disp_src, mode_code,
                hold_active, state_dbg};

  // Field order: run_total run_lap clr_total clr_lap snap_load disp_src mode_code hold_active state
  function automatic logic [13:0] pk(input logic rt, input logic rl, input logic ct,
                                     input logic cl, input logic sl, input logic [1:0] ds,
                                     input logic [3:0] mc, input logic ha, input logic [1:0] st);
    return {rt, rl, ct, cl, sl, ds, mc, ha, st};
  endfunction

  // Expected outputs k ticks into a hold (no exit yet); blink starts on and flips every 5 ticks.
  function automatic logic [13:0] hold_exp(input int k, input logic m);
    logic b;
    b = ((k / 5) % 2) == 0;
    return pk(1, 1, 0, 0, 0, 2'd2, b ? 4'd11 : (m ? 4'd10 : 4'd5), 1, S_HOLD);
  endfunction

  task automatic check(input string name, input logic [13:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b (rt rl ct cl sl ds mc ha st)", name, obs, exp);
    end
  endtask

  task automatic step(input logic ss, input logic lc, input logic ms, input logic tk);
    start_stop = ss; lap_clear = lc; mode_sel = ms; tick = tk;
    @(posedge CLOCK_50);
    #1;
    start_stop = 0; lap_clear = 0; mode_sel = 0; tick = 0;
  endtask

  task automatic add(input logic ss, input logic lc, input logic ms, input logic tk,
                     input logic [13:0] e, input string nm);
    vec_t v;
    v.ss = ss; v.lc = lc; v.ms = ms; v.tk = tk; v.exp = e; v.name = nm;
    vecs.push_back(v);
  endtask

  // Apply n ticks (with an idle cycle after each) inside HOLD; optionally expect exit on the last.
  task automatic run_hold(input int n, input bit exit_last, input logic m, input string nm);
    logic [13:0] e;
    for (int k = 1; k <= n; k++) begin
      if (exit_last && k == n) e = pk(1, 1, 0, 0, 0, {1'b0, m}, m ? 4'd10 : 4'd5, 0, S_RUN);
      else                     e = hold_exp(k, m);
      step(0, 0, 0, 1);
      check($sformatf("%s_tick%0d", nm, k), e);
      step(0, 0, 0, 0);
      check($sformatf("%s_idle%0d", nm, k), e);
    end
  endtask

  initial begin
    add(0,0,0,0, pk(0,0,0,0,0,0,4'd5, 0,S_IDLE),  "idle_quiet");
    add(0,1,0,0, pk(0,0,1,1,0,0,4'd5, 0,S_IDLE),  "idle_clear");
    add(0,0,0,0, pk(0,0,0,0,0,0,4'd5, 0,S_IDLE),  "idle_clear_drop");
    add(0,0,1,0, pk(0,0,0,0,0,1,4'd10,0,S_IDLE),  "idle_mode_lap");
    add(0,0,1,0, pk(0,0,0,0,0,0,4'd5, 0,S_IDLE),  "idle_mode_total");
    add(1,0,0,0, pk(1,1,0,0,0,0,4'd5, 0,S_RUN),   "start");
    add(0,0,0,1, pk(1,1,0,0,0,0,4'd5, 0,S_RUN),   "run_tick");
    add(1,0,0,0, pk(0,0,0,0,0,0,4'd5, 0,S_PAUSE), "stop");
    add(1,0,0,0, pk(1,1,0,0,0,0,4'd5, 0,S_RUN),   "resume_no_clr");
    add(0,0,1,0, pk(1,1,0,0,0,1,4'd10,0,S_RUN),   "run_mode_lap");
    add(1,1,1,0, pk(0,0,0,0,0,1,4'd10,0,S_PAUSE), "all_three_pause_only");
    add(1,0,0,0, pk(1,1,0,0,0,1,4'd10,0,S_RUN),   "resume2");
    add(0,1,1,0, pk(1,1,0,1,1,2,4'd11,1,S_HOLD),  "lap_beats_mode");
    add(0,0,0,0, pk(1,1,0,0,0,2,4'd11,1,S_HOLD),  "snap_single_cycle");
    add(0,0,1,0, pk(1,1,0,0,0,2,4'd11,1,S_HOLD),  "hold_mode_toggle");
    add(1,0,0,0, pk(0,0,0,0,0,0,4'd5, 0,S_PAUSE), "hold_stop_live");
    add(0,1,0,0, pk(0,0,1,1,0,0,4'd5, 0,S_IDLE),  "pause_clear");
    add(0,0,0,0, pk(0,0,0,0,0,0,4'd5, 0,S_IDLE),  "pause_clear_drop");
    add(0,0,0,1, pk(0,0,0,0,0,0,4'd5, 0,S_IDLE),  "idle_tick");

    // Reset held for three edges, then released.
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLOCK_50);
      #1;
      check($sformatf("reset_edge%0d", i), pk(0,0,1,1,0,0,4'd5,0,S_IDLE));
    end
    reset = 1'b0;
    check("reset_release_cycle", pk(0,0,1,1,0,0,4'd5,0,S_IDLE));

    foreach (vecs[i]) begin
      step(vecs[i].ss, vecs[i].lc, vecs[i].ms, vecs[i].tk);
      check(vecs[i].name, vecs[i].exp);
    end

    // Full hold: exit to RUN exactly on the 50th tick.
    step(1, 0, 0, 0);
    check("a_start", pk(1,1,0,0,0,0,4'd5,0,S_RUN));
    step(0, 1, 0, 0);
    check("a_lap", pk(1,1,0,1,1,2,4'd11,1,S_HOLD));
    run_hold(50, 1, 1'b0, "a");

    // Retrigger at tick 30: 80 ticks in total before returning to RUN.
    step(0, 1, 0, 0);
    check("b_lap", pk(1,1,0,1,1,2,4'd11,1,S_HOLD));
    run_hold(30, 0, 1'b0, "b1");
    step(0, 1, 0, 0);
    check("b_relap", pk(1,1,0,1,1,2,4'd11,1,S_HOLD));
    run_hold(50, 1, 1'b0, "b2");

    // Reset in the middle of a hold with the lap channel selected.
    step(0, 0, 1, 0);
    check("c_mode_lap", pk(1,1,0,0,0,1,4'd10,0,S_RUN));
    step(0, 1, 0, 0);
    check("c_lap", pk(1,1,0,1,1,2,4'd11,1,S_HOLD));
    run_hold(7, 0, 1'b1, "c");
    reset = 1'b1;
    step(0, 0, 0, 0);
    check("c_reset_mid_hold", pk(0,0,1,1,0,0,4'd5,0,S_IDLE));
    reset = 1'b0;
    step(0, 0, 0, 0);
    check("c_after_reset", pk(0,0,0,0,0,0,4'd5,0,S_IDLE));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
